// File: rtl/amul_err_stats_if.sv
// Sample-in / record-out handshake bundle for the approximate-multiplier error statistics stage.
interface amul_err_stats_if #(
    parameter int WIN_LOG2 = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [7:0]                 x;
    logic [7:0]                 y;
    logic [15:0]                z_apx;
    logic                       out_valid;
    logic                       out_ready;
    logic [16+WIN_LOG2-1:0]     sum_abs_err;
    logic [32+WIN_LOG2-1:0]     sum_sq_err;
    logic [17+WIN_LOG2-1:0]     bias;
    logic [15:0]                max_abs_err;
    logic [WIN_LOG2:0]          err_count;

    modport master (
        output in_valid, x, y, z_apx, out_ready,
        input  in_ready, out_valid, sum_abs_err, sum_sq_err, bias, max_abs_err, err_count
    );

    modport slave (
        input  in_valid, x, y, z_apx, out_ready,
        output in_ready, out_valid, sum_abs_err, sum_sq_err, bias, max_abs_err, err_count
    );
endinterface

// File: rtl/amul_err_stats.sv
// Windowed error statistics (abs, squared, signed bias, max, count) of an 8x8 approximate
// multiplier against the exact product, reported once per 2^WIN_LOG2 samples.
//
// state    | meaning
// S_ACCUM  | accepting samples, accumulating
// S_DRAIN  | window full, last stage-1 sample being accumulated
// S_REPORT | record presented, waiting for out_ready
module amul_err_stats #(
    parameter int WIN_LOG2 = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    amul_err_stats_if.slave   bus
);
    localparam logic [1:0] S_ACCUM  = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    localparam logic [WIN_LOG2:0] C_LAST = {1'b0, {WIN_LOG2{1'b1}}};
    localparam logic [WIN_LOG2:0] C_ONE  = {{WIN_LOG2{1'b0}}, 1'b1};

    logic [1:0]                 r_state;
    logic [WIN_LOG2:0]          r_cnt;
    logic                       r_s1_v;
    logic [7:0]                 r_x;
    logic [7:0]                 r_y;
    logic [15:0]                r_z;
    logic [16+WIN_LOG2-1:0]     r_sum_abs;
    logic [32+WIN_LOG2-1:0]     r_sum_sq;
    logic [17+WIN_LOG2-1:0]     r_bias;
    logic [15:0]                r_max;
    logic [WIN_LOG2:0]          r_err_cnt;

    logic                       w_in_ready;
    logic                       w_accept;
    logic [15:0]                w_prod;
    logic [16:0]                w_err;
    logic [15:0]                w_abs;
    logic [31:0]                w_sq;
    logic                       w_nz;

    assign w_in_ready = (r_state == S_ACCUM);
    assign w_accept   = bus.in_valid && w_in_ready;

    assign w_prod = {8'd0, r_x} * {8'd0, r_y};
    assign w_err  = {1'b0, r_z} - {1'b0, w_prod};
    // Magnitude taken from the ordered difference so no 17-bit negate is needed.
    assign w_abs  = (r_z >= w_prod) ? (r_z - w_prod) : (w_prod - r_z);
    assign w_sq   = {16'd0, w_abs} * {16'd0, w_abs};
    assign w_nz   = (r_z != w_prod);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_ACCUM;
            r_cnt     <= '0;
            r_s1_v    <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_sum_abs <= '0;
            r_sum_sq  <= '0;
            r_bias    <= '0;
            r_max     <= '0;
            r_err_cnt <= '0;
        end else if (i_clear) begin
            r_state   <= S_ACCUM;
            r_cnt     <= '0;
            r_s1_v    <= 1'b0;
            r_sum_abs <= '0;
            r_sum_sq  <= '0;
            r_bias    <= '0;
            r_max     <= '0;
            r_err_cnt <= '0;
        end else begin
            r_s1_v <= w_accept;
            if (w_accept) begin
                r_x <= bus.x;
                r_y <= bus.y;
                r_z <= bus.z_apx;
            end

            if (r_s1_v) begin
                r_sum_abs <= r_sum_abs + {{WIN_LOG2{1'b0}}, w_abs};
                r_sum_sq  <= r_sum_sq + {{WIN_LOG2{1'b0}}, w_sq};
                r_bias    <= r_bias + {{WIN_LOG2{w_err[16]}}, w_err};
                r_err_cnt <= r_err_cnt + {{WIN_LOG2{1'b0}}, w_nz};
                if (w_abs > r_max)
                    r_max <= w_abs;
            end

            case (r_state)
                S_ACCUM: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + C_ONE;
                        if (r_cnt == C_LAST)
                            r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: r_state <= S_REPORT;
                S_REPORT: begin
                    // s1_v is always 0 here, so this zeroing cannot race an accumulate.
                    if (bus.out_ready) begin
                        r_state   <= S_ACCUM;
                        r_cnt     <= '0;
                        r_sum_abs <= '0;
                        r_sum_sq  <= '0;
                        r_bias    <= '0;
                        r_max     <= '0;
                        r_err_cnt <= '0;
                    end
                end
                default: r_state <= S_ACCUM;
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = (r_state == S_REPORT);
    assign bus.sum_abs_err = r_sum_abs;
    assign bus.sum_sq_err  = r_sum_sq;
    assign bus.bias        = r_bias;
    assign bus.max_abs_err = r_max;
    assign bus.err_count   = r_err_cnt;
endmodule

// File: tb/tb_amul_err_stats.sv
// Directed-vector bench for amul_err_stats: window-of-4 instance plus a window-of-2 full-width instance.
module tb_amul_err_stats;
    logic clk = 1'b0;
    logic rst;
    logic clear;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    amul_err_stats_if #(.WIN_LOG2(2)) ifa ();
    amul_err_stats_if #(.WIN_LOG2(1)) ifb ();

    amul_err_stats #(.WIN_LOG2(2)) u_dut_a (.i_clk(clk), .i_rst(rst), .i_clear(clear), .bus(ifa));
    amul_err_stats #(.WIN_LOG2(1)) u_dut_b (.i_clk(clk), .i_rst(rst), .i_clear(1'b0), .bus(ifb));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [15:0] z);
        ifa.in_valid = 1'b1;
        ifa.x        = x;
        ifa.y        = y;
        ifa.z_apx    = z;
        step();
        ifa.in_valid = 1'b0;
    endtask

    task automatic chk_stats(input string tag, input logic [63:0] sa, input logic [63:0] sq,
                             input logic [63:0] bi, input logic [63:0] mx, input logic [63:0] ec);
        chk({tag, ".sum_abs"}, 64'(ifa.sum_abs_err), sa);
        chk({tag, ".sum_sq"},  64'(ifa.sum_sq_err),  sq);
        chk({tag, ".bias"},    64'(ifa.bias),        bi);
        chk({tag, ".max"},     64'(ifa.max_abs_err), mx);
        chk({tag, ".count"},   64'(ifa.err_count),   ec);
    endtask

    task automatic send_mixed();
        send(8'd10, 8'd10, 16'd105);
        send(8'd2, 8'd3, 16'd4);
        send(8'd255, 8'd255, 16'd65535);
        send(8'd0, 8'd0, 16'd0);
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        ifa.in_valid = 1'b0; ifa.x = '0; ifa.y = '0; ifa.z_apx = '0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.x = '0; ifb.y = '0; ifb.z_apx = '0; ifb.out_ready = 1'b0;
        #12;
        chk("rst.in_ready", 64'(ifa.in_ready), 64'd1);
        chk("rst.out_valid", 64'(ifa.out_valid), 64'd0);
        chk_stats("rst", 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;

        // Exact products; out_ready raised during DRAIN (ignored) so transfer happens at E+2.
        send(8'd3, 8'd5, 16'd15);
        send(8'd7, 8'd9, 16'd63);
        send(8'd0, 8'd200, 16'd0);
        send(8'd255, 8'd255, 16'd65025);
        chk("exact.drain_in_ready", 64'(ifa.in_ready), 64'd0);
        chk("exact.drain_out_valid", 64'(ifa.out_valid), 64'd0);
        ifa.out_ready = 1'b1;
        step();
        chk("exact.out_valid", 64'(ifa.out_valid), 64'd1);
        chk_stats("exact", 0, 0, 0, 0, 0);
        step();
        chk("exact.done_out_valid", 64'(ifa.out_valid), 64'd0);
        chk("exact.done_in_ready", 64'(ifa.in_ready), 64'd1);
        ifa.out_ready = 1'b0;

        // Mixed errors with 5 cycles of backpressure and ignored in_valid pulses.
        send_mixed();
        step();
        chk("mixed.out_valid", 64'(ifa.out_valid), 64'd1);
        chk_stats("mixed", 517, 260129, 513, 510, 3);
        for (int i = 0; i < 5; i++) begin
            ifa.in_valid = 1'b1; ifa.x = 8'd0; ifa.y = 8'd0; ifa.z_apx = 16'd100;
            step();
            chk("bp.out_valid", 64'(ifa.out_valid), 64'd1);
            chk("bp.in_ready", 64'(ifa.in_ready), 64'd0);
            chk("bp.sum_abs", 64'(ifa.sum_abs_err), 64'd517);
            chk("bp.count", 64'(ifa.err_count), 64'd3);
        end
        ifa.out_ready = 1'b1;
        step();
        ifa.in_valid = 1'b0;
        ifa.out_ready = 1'b0;
        chk("bp.done_out_valid", 64'(ifa.out_valid), 64'd0);
        chk("bp.done_in_ready", 64'(ifa.in_ready), 64'd1);

        // Clear mid-window, with a sample offered on the clear edge.
        send(8'd1, 8'd1, 16'd9);
        send(8'd4, 8'd4, 16'd0);
        ifa.in_valid = 1'b1; ifa.x = 8'd5; ifa.y = 8'd5; ifa.z_apx = 16'd30;
        clear = 1'b1;
        step();
        clear = 1'b0;
        ifa.in_valid = 1'b0;
        chk("clr.in_ready", 64'(ifa.in_ready), 64'd1);
        chk("clr.sum_abs", 64'(ifa.sum_abs_err), 64'd0);
        step();
        chk("clr.sum_abs_idle", 64'(ifa.sum_abs_err), 64'd0);
        send_mixed();
        chk("clr.drain_in_ready", 64'(ifa.in_ready), 64'd0);
        step();
        chk("clr.out_valid", 64'(ifa.out_valid), 64'd1);
        chk_stats("clr", 517, 260129, 513, 510, 3);
        ifa.out_ready = 1'b1;
        step();
        ifa.out_ready = 1'b0;

        // Negative bias and a max tie: errors -2, -2, 0, 0.
        send(8'd2, 8'd3, 16'd4);
        send(8'd3, 8'd1, 16'd1);
        send(8'd0, 8'd0, 16'd0);
        send(8'd1, 8'd1, 16'd1);
        step();
        chk("neg.out_valid", 64'(ifa.out_valid), 64'd1);
        chk_stats("neg", 4, 8, 64'h7FFFC, 2, 2);
        ifa.out_ready = 1'b1;
        step();
        ifa.out_ready = 1'b0;

        // Asynchronous reset in the middle of REPORT.
        send_mixed();
        step();
        chk("rstrep.out_valid_before", 64'(ifa.out_valid), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("rstrep.in_ready", 64'(ifa.in_ready), 64'd1);
        chk("rstrep.out_valid", 64'(ifa.out_valid), 64'd0);
        chk_stats("rstrep", 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;

        // Full-width corner on the window-of-2 instance.
        ifb.in_valid = 1'b1; ifb.x = 8'd0; ifb.y = 8'd0; ifb.z_apx = 16'd65535;
        step();
        step();
        ifb.in_valid = 1'b0;
        chk("fw.drain_in_ready", 64'(ifb.in_ready), 64'd0);
        step();
        chk("fw.out_valid", 64'(ifb.out_valid), 64'd1);
        chk("fw.sum_sq", 64'(ifb.sum_sq_err), 64'd8589672450);
        chk("fw.sum_abs", 64'(ifb.sum_abs_err), 64'd131070);
        chk("fw.bias", 64'(ifb.bias), 64'd131070);
        chk("fw.max", 64'(ifb.max_abs_err), 64'd65535);
        chk("fw.count", 64'(ifb.err_count), 64'd2);
        ifb.out_ready = 1'b1;
        step();
        chk("fw.done_out_valid", 64'(ifb.out_valid), 64'd0);
        ifb.out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/amul_err_stats.md
# amul_err_stats

Sequential error-statistics stage placed directly downstream of an unsigned 8x8 approximate multiplier. Each cycle it accepts an operand pair together with the multiplier's approximate product z_apx. It recomputes the exact product internally and accumulates error metrics over a fixed window of 2^WIN_LOG2 samples. At the end of the window it presents one result record over a valid/ready handshake. The block is used in hardware characterisation of approximate multipliers, for example computing the squared-error cost on-chip.

## Interface
- WIN_LOG2, default 8 — window length is 2^WIN_LOG2 samples; legal range 1..16.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort. Discards the current window and the pipeline, and returns to ACCUM.
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts a sample this cycle.
- x  in  8  multiplicand, unsigned.
- y  in  8  multiplier, unsigned.
- z_apx  in  16  approximate product of x and y, unsigned, same cycle as x/y.
- out_valid  out  1  result record valid.
- out_ready  in  1  consumer takes the record.
- sum_abs_err  out  16+WIN_LOG2  sum of |z_apx − x·y|.
- sum_sq_err  out  32+WIN_LOG2  sum of (z_apx − x·y)².
- bias  out  17+WIN_LOG2  signed two's-complement sum of (z_apx − x·y).
- max_abs_err  out  16  largest |error| in the window.
- err_count  out  WIN_LOG2+1  number of samples with nonzero error.

## Operation
- Handshake: a sample is accepted on a rising edge where in_valid && in_ready.
- Stage 1 registers x, y and z_apx plus a valid bit s1_v.
- Stage 2 operates from the stage-1 registers:
  - err = {1'b0,z_apx} − {1'b0,x·y}, 17-bit signed; range −65025..+65535.
  - abs = |err|, 16 bits.
  - sq = abs·abs, 32 bits.
  - All of these are accumulated into the stats registers on the next edge when s1_v = 1.
- Accumulators are sized so they cannot overflow within one window; no saturation logic is needed.
- A sample counter counts accepted samples from 0 to 2^WIN_LOG2 (WIN_LOG2+1 bits).
- State machine:
  - ACCUM: in_ready = 1. The accept that brings the counter to 2^WIN_LOG2 moves the FSM to DRAIN.
  - DRAIN: in_ready = 0. Lasts one cycle while the final stage-1 sample is accumulated, then moves to REPORT.
  - REPORT: in_ready = 0, out_valid = 1.
    - All stats outputs are held stable until out_ready = 1.
    - On the out_ready edge: accumulators, counter and max are zeroed, and the FSM returns to ACCUM.
- Stats outputs are driven directly from the accumulator registers. They are only meaningful while out_valid = 1.
- clear = 1 at an edge, in any state:
  - zeroes the accumulators, counter, max and s1_v;
  - moves the FSM to ACCUM;
  - takes priority over accept, accumulate and report. A sample offered in the same cycle is dropped, even though in_ready reads 1 if the FSM was in ACCUM.
- max_abs_err update rule: max ← abs when abs > max; ties leave it unchanged.

## Timing
- Reset values: in_ready = 1, out_valid = 0, all stats outputs 0, s1_v = 0, FSM = ACCUM.
- Reset asynchronously overrides everything, including mid-DRAIN and mid-REPORT. The record in progress is lost.
- Sample accepted at edge k is reflected in the accumulators after edge k+1.
- Last sample of the window accepted at edge E:
  - FSM = DRAIN after E;
  - out_valid = 1 after E+1.
- If out_ready = 1 already during the first REPORT cycle, the record transfers at edge E+2. in_ready = 1 again after E+2.
- Minimum window period is 2^WIN_LOG2 + 2 cycles.
- in_valid is ignored whenever in_ready = 0; no sample is buffered.
- out_ready is ignored outside REPORT.

## Test plan
All scenarios use WIN_LOG2 = 2 (window of 4) unless noted.
- **Reset:** assert rst mid-cycle.
  - Outputs go immediately to in_ready = 1, out_valid = 0, all stats 0.
- **Exact products:** stream (3,5,15), (7,9,63), (0,200,0), (255,255,65025).
  - out_valid rises 2 cycles after the 4th accept.
  - All sums 0, max 0, err_count 0.
- **Mixed errors:** stream (10,10,105), (2,3,4), (255,255,65535), (0,0,0).
  - sum_abs_err = 517, sum_sq_err = 260129, bias = +513, max_abs_err = 510, err_count = 3.
- **Output backpressure:** hold out_ready = 0 for 5 cycles in REPORT.
  - out_valid stays 1 and stats stay stable.
  - in_ready stays 0; in_valid pulses are not counted.
  - Accept resumes the cycle after the out_ready edge.
- **Clear mid-window:** feed 2 error samples, pulse clear together with a third sample, then feed the mixed-error set.
  - The report equals the mixed-error values exactly.
- **Full-width corner:** WIN_LOG2 = 1, two samples of (0,0,65535).
  - sum_sq_err = 8589672450, sum_abs_err = 131070, bias = +131070, max_abs_err = 65535, err_count = 2.
